// File: rtl/folded_maj_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// folded_maj_pkg
// Shared definitions for the folded majority/threshold sequencer:
//   - state_e          : controller state encoding (IDLE, RUN, DONE)
//   - chunk_count      : number of W-bit chunks needed to cover N bits
//   - last_chunk_size  : number of real (non-padding) bits in the final chunk
//   - count_width      : width of count/threshold/remaining-bits registers,
//                        wide enough to hold thresholds up to N+1
// ---------------------------------------------------------------------------
package folded_maj_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int chunk_count(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  function automatic int last_chunk_size(input int n, input int w);
    return n - (chunk_count(n, w) - 1) * w;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/folded_maj_sequencer_if.sv
// ---------------------------------------------------------------------------
// folded_maj_sequencer_if
// Operand and result handshake bundle for the folded majority sequencer.
//   in_valid/in_ready   : operand handshake (producer -> sequencer)
//   in_x [N]            : operand vector
//   in_thr [CW]         : decision threshold
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   out_y               : threshold decision
//   out_count [CW]      : ones accumulated up to the deciding chunk
//   out_early           : decision reached before the last chunk
// Modports: slave = the sequencer, master = the surrounding logic.
// ---------------------------------------------------------------------------
interface folded_maj_sequencer_if
  import folded_maj_pkg::*;
#(
  parameter int N = 33
);

  localparam int CW = count_width(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_x;
  logic [CW-1:0] in_thr;
  logic          out_valid;
  logic          out_ready;
  logic          out_y;
  logic [CW-1:0] out_count;
  logic          out_early;

  modport slave (
    input  in_valid, in_x, in_thr, out_ready,
    output in_ready, out_valid, out_y, out_count, out_early
  );

  modport master (
    output in_valid, in_x, in_thr, out_ready,
    input  in_ready, out_valid, out_y, out_count, out_early
  );

endinterface

// File: rtl/folded_maj_sequencer_chunk_popcount.sv
// ---------------------------------------------------------------------------
// chunk_popcount
// Purely combinational ones counter for one W-bit chunk. This is the single
// shared slice that the sequencer folds the whole operand through.
//   vec_i   [W]             : chunk bits
//   count_o [clog2(W+1)]    : number of ones in vec_i
// ---------------------------------------------------------------------------
module chunk_popcount #(
  parameter  int W  = 8,
  localparam int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [PW-1:0] count_o
);

  // Simple adder chain over the chunk bits; W is small so depth is modest.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + PW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/folded_maj_sequencer.sv
// ---------------------------------------------------------------------------
// folded_maj_sequencer
// Evaluates y = (popcount(x) >= thr) over an N-bit operand by feeding one
// W-bit chunk per cycle through a shared popcount slice. The running ones
// count and the number of still-unseen bits let the controller stop as soon
// as the outcome can no longer change.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   busy   : high whenever the controller is not idle
//   bus    : operand/result handshake (slave side of folded_maj_sequencer_if)
// ---------------------------------------------------------------------------
module folded_maj_sequencer
  import folded_maj_pkg::*;
#(
  parameter int N = 33,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic busy,
  folded_maj_sequencer_if.slave bus
);

  localparam int NCHUNK = chunk_count(N, W);
  localparam int LAST   = last_chunk_size(N, W);
  localparam int CW     = count_width(N);
  localparam int CW1    = CW + 1;
  localparam int PW     = $clog2(W + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int XW     = NCHUNK * W;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] xs_q, xs_d;
  logic [CW-1:0] thr_q, thr_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          y_q, y_d;
  logic [CW-1:0] count_q, count_d;
  logic          early_q, early_d;

  logic [PW-1:0] chunkOnes;
  logic          isLast;
  logic [CW:0]   chunkSize;
  logic [CW:0]   accNext;
  logic [CW:0]   remNext;
  logic [CW:0]   reachNext;
  logic [CW:0]   thrWide;

  // The operand is kept zero-padded to a whole number of chunks and shifted
  // down one chunk per cycle, so the slice always sees the low W bits.
  chunk_popcount #(.W(W)) u_chunk_popcount (
    .vec_i   (xs_q[W-1:0]),
    .count_o (chunkOnes)
  );

  // Per-chunk arithmetic, one bit wider than the registers so that
  // acc'+rem' can never wrap before being compared with the threshold.
  always_comb begin
    isLast    = (idx_q == IW'(NCHUNK - 1));
    chunkSize = isLast ? CW1'(LAST) : CW1'(W);
    accNext   = {1'b0, acc_q} + CW1'(chunkOnes);
    remNext   = {1'b0, rem_q} - chunkSize;
    reachNext = accNext + remNext;
    thrWide   = {1'b0, thr_q};
  end

  // Next-state logic: load in IDLE, fold a chunk per cycle in RUN and leave
  // as soon as the count either reaches the threshold or provably cannot.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    y_d     = y_q;
    count_d = count_q;
    early_d = early_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          xs_d    = XW'(bus.in_x);
          thr_d   = bus.in_thr;
          acc_d   = '0;
          rem_d   = CW'(N);
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        xs_d  = xs_q >> W;
        acc_d = accNext[CW-1:0];
        rem_d = remNext[CW-1:0];
        idx_d = idx_q + IW'(1);
        if (accNext >= thrWide) begin
          y_d     = 1'b1;
          count_d = accNext[CW-1:0];
          early_d = !isLast;
          state_d = ST_DONE;
        end else if (reachNext < thrWide) begin
          y_d     = 1'b0;
          count_d = accNext[CW-1:0];
          early_d = !isLast;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      thr_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      y_q     <= 1'b0;
      count_q <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      count_q <= count_d;
      early_q <= early_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_y     = y_q;
  assign bus.out_count = count_q;
  assign bus.out_early = early_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_folded_maj_sequencer.sv
// ---------------------------------------------------------------------------
// tb_folded_maj_sequencer
// Scoreboard bench: each accepted operand pushes its expected result, and a
// monitor pops and compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_folded_maj_sequencer;
  import folded_maj_pkg::*;

  localparam int N      = 33;
  localparam int W      = 8;
  localparam int NCHUNK = chunk_count(N, W);
  localparam int CW     = count_width(N);

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  folded_maj_sequencer_if #(.N(N)) bus ();

  folded_maj_sequencer #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int count;
    int early;
    int k;
    int ythr;
    int acceptEdge;
  } expect_t;

  expect_t sbQueue[$];
  expect_t monE;
  int vectorCount = 0;
  int missCount   = 0;
  int edgeCount   = 0;
  int readyMode   = 0;
  int riseEdge    = 0;
  logic prevValid = 1'b0;

  logic [N-1:0] onesX;
  logic [N-1:0] x3;
  logic [N-1:0] x4;
  logic [N-1:0] rx;
  expect_t bp;

  // Count rising edges so result latency can be measured in edges.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference behaviour: walk the chunks, stop at the first decided chunk.
  function automatic expect_t modelOf(input logic [N-1:0] x, input int thr);
    expect_t e;
    int acc = 0;
    int rem = N;
    int k = 0;
    int csize;
    int y = 0;
    for (int c = 0; c < NCHUNK; c++) begin
      csize = (c == NCHUNK - 1) ? (N - (NCHUNK - 1) * W) : W;
      for (int b = 0; b < csize; b++) acc += int'(x[c * W + b]);
      rem -= csize;
      k = c + 1;
      if (acc >= thr) begin
        y = 1;
        break;
      end
      if (acc + rem < thr) begin
        y = 0;
        break;
      end
    end
    e.y = y;
    e.count = acc;
    e.early = (k != NCHUNK) ? 1 : 0;
    e.k = k;
    e.ythr = ($countones(x) >= thr) ? 1 : 0;
    e.acceptEdge = 0;
    return e;
  endfunction

  // Offer one operand starting at a falling edge; returns at the falling
  // edge after it was accepted.
  task automatic applyStimulus(input logic [N-1:0] x, input int thr);
    expect_t e;
    int waited = 0;
    e = modelOf(x, thr);
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_thr = CW'(thr);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", 0, 1);
    end else begin
      e.acceptEdge = edgeCount + 1;
      sbQueue.push_back(e);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbQueue.size() != 0) checkOutput("drainTimeout", sbQueue.size(), 0);
    @(negedge clk);
  endtask

  task automatic waitValid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) checkOutput("validTimeout", 0, 1);
  endtask

  // Consumer side: drive out_ready just after each falling edge and score
  // any result that will be handed over on the next rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
      if (bus.out_valid && !prevValid) riseEdge = edgeCount;
      prevValid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpectedResult", 1, 0);
        end else begin
          monE = sbQueue.pop_front();
          checkOutput("outY", int'(bus.out_y), monE.y);
          checkOutput("outCount", int'(bus.out_count), monE.count);
          checkOutput("outEarly", int'(bus.out_early), monE.early);
          checkOutput("latency", riseEdge - monE.acceptEdge, monE.k);
          checkOutput("yVsPopcount", int'(bus.out_y), monE.ythr);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    onesX = '1;
    x3 = {17'h1FFFF, 16'h0000};
    x4 = {16'hFFFF, 17'h00000};
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_thr = '0;
    readyMode = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rstOutValid", int'(bus.out_valid), 0);
    checkOutput("rstOutY", int'(bus.out_y), 0);
    checkOutput("rstOutCount", int'(bus.out_count), 0);
    checkOutput("rstOutEarly", int'(bus.out_early), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstInReady", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: early accept, early reject, full run, thresholds.
    applyStimulus(onesX, 17);
    waitDrain();
    applyStimulus('0, 17);
    waitDrain();
    applyStimulus(x3, 17);
    waitDrain();
    applyStimulus(x4, 17);
    waitDrain();
    applyStimulus(x4, 0);
    waitDrain();
    applyStimulus(x4, 34);
    waitDrain();

    // Backpressure: result must hold while in_valid is pulsed.
    bp = modelOf(onesX, 17);
    readyMode = 2;
    applyStimulus(onesX, 17);
    waitValid();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x = N'({$urandom, $urandom});
      bus.in_thr = '0;
      checkOutput("bpOutValid", int'(bus.out_valid), 1);
      checkOutput("bpOutY", int'(bus.out_y), bp.y);
      checkOutput("bpOutCount", int'(bus.out_count), bp.count);
      checkOutput("bpInReady", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    readyMode = 0;
    @(negedge clk);
    checkOutput("bpIdleInReady", int'(bus.in_ready), 1);
    checkOutput("bpIdleOutValid", int'(bus.out_valid), 0);
    checkOutput("bpIdleBusy", int'(busy), 0);
    checkOutput("bpQueueEmpty", sbQueue.size(), 0);

    // Reset in the middle of a full-length run.
    applyStimulus(x3, 17);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstInReady", int'(bus.in_ready), 1);
    checkOutput("midRstOutValid", int'(bus.out_valid), 0);
    checkOutput("midRstOutCount", int'(bus.out_count), 0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(onesX, 17);
    waitDrain();

    // Reset while a result is being held.
    readyMode = 2;
    applyStimulus(onesX, 17);
    waitValid();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("doneRstOutValid", int'(bus.out_valid), 0);
    checkOutput("doneRstOutY", int'(bus.out_y), 0);
    checkOutput("doneRstOutCount", int'(bus.out_count), 0);
    checkOutput("doneRstOutEarly", int'(bus.out_early), 0);
    checkOutput("doneRstInReady", int'(bus.in_ready), 1);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    readyMode = 0;
    @(negedge clk);

    // Back-to-back random sweep with random consumer stalls.
    readyMode = 1;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 15))
        0:       rx = '0;
        1:       rx = '1;
        default: rx = N'({$urandom, $urandom});
      endcase
      applyStimulus(rx, int'($urandom_range(0, 34)));
    end
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/folded_maj_sequencer.md
Name: folded_maj_sequencer

Overview:
Sequential controller that evaluates an N-input majority/threshold function by folding the input vector through one shared W-bit popcount slice, one chunk per cycle. It accumulates the ones count and terminates early as soon as the outcome is decided. It sits in front of the folded-majority datapath as its scheduler, taking operand vectors over a valid/ready handshake and returning the decision plus the partial count. Default configuration (N=33, threshold 17) matches the team's Maj33 reference function.

Parameters:
N, 33, input vector width (≥2)
W, 8, chunk width processed per cycle (1..N)
NCHUNK, ceil(N/W) (derived, localparam), number of chunks; 5 at defaults
CW, $clog2(N+2) (derived, localparam), width of count, threshold and remaining-bits registers

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand offered
in_ready  output  1  block can accept operand (high only in IDLE)
in_x  input  N  operand vector; bit i is input x_i
in_thr  input  CW  threshold; y=1 iff popcount(in_x) ≥ in_thr
out_valid  output  1  result held
out_ready  input  1  consumer accepts result
out_y  output  1  threshold decision
out_count  output  CW  ones accumulated up to the decision chunk
out_early  output  1  decided before the last chunk
busy  output  1  state != IDLE

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n. There is one clock domain.
- Reset: state=IDLE; out_valid=0, out_y=0, out_count=0, out_early=0, busy=0. Internal regs are cleared. in_ready=1 because it decodes combinationally from state==IDLE.
- States: IDLE, RUN, DONE.
- IDLE: on the edge with in_valid&&in_ready (E0):
  - latch in_x and in_thr
  - acc=0, idx=0, rem=N
  - next state RUN
- RUN, one chunk per edge E(i+1):
  - csize = W for all chunks except the last, which is N-(NCHUNK-1)*W. Bits above N-1 in the last chunk are zero-padded.
  - acc' = acc + popcount(x[idx*W +: csize])
  - rem' = rem - csize
  - idx' = idx + 1
  - Decision is evaluated on acc' and rem':
    - if acc' ≥ thr: y=1
    - else if acc' + rem' < thr: y=0
    - otherwise stay in RUN
  - On a decision, register out_y and out_count=acc'. Set out_early = (idx ≠ NCHUNK-1). Go to DONE.
  - At the last chunk rem'=0, so a decision is guaranteed.
  - All compares use CW+1 bits so acc'+rem' never overflows.
- DONE: out_valid=1 and outputs are stable. On out_valid&&out_ready, go to IDLE and clear out_valid. There is no same-cycle re-accept; the next operand is accepted no earlier than the following cycle.
- Latency from E0: out_valid is high after edge E(k), where k is the decision chunk count, 1..NCHUNK. A full run at defaults is 5 cycles.
- Threshold edge cases:
  - thr=0: y=1 at E1.
  - thr>N: y=0 at E1, because acc'+rem' ≤ N.
- in_valid outside IDLE is ignored. in_x and in_thr are not sampled.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The pending result is discarded.

Decomposition:
- Package folded_maj_pkg:
  - state enum {IDLE,RUN,DONE}
  - functions chunk_count(N,W) and last_chunk_size(N,W)
  - CW calculation
- Sub-module chunk_popcount (combinational, parameter W): W-bit vector to $clog2(W+1)-bit count. The controller instantiates it once; this is the shared folded slice.

Test Plan:
1. N=33, W=8, x=all ones, thr=17 → chunk sums 8,16,24; out_valid after E3; y=1, count=24, early=1.
2. x=0, thr=17 → after E3 acc=0, rem=9, 0+9<17; y=0, count=0, early=1.
3. Ones on bits 16..32 (exactly 17), thr=17 → no early decision possible; out_valid after E5; y=1, count=17, early=0.
4. Ones on bits 17..32 (16 ones), thr=17 → E3: acc=7, rem=9, 16<17; y=0, count=7, early=1. Also check:
   - thr=0 → y=1 at E1, count=0
   - thr=34 → y=0 at E1
5. Backpressure: case 1 with out_ready low for 4 cycles, in_valid pulsed during the wait → out_valid, out_y, out_count stable; in_ready=0; no operand consumed. After the accept edge: IDLE, in_ready=1, out_valid=0.
6. rst_n pulsed low at E2 of case 3 → outputs go to 0 asynchronously and in_ready=1. A fresh operand x=all ones, thr=17 afterwards gives a result identical to case 1.
7. Back-to-back random sweep (≥10k vectors, random thr 0..34, random out_ready) → out_y == (popcount(x) ≥ thr) for every accepted operand.
